// File: rtl/hazard_forward_unit.sv
// RAW hazard unit: tracks in-flight destination writes, drives operand forwarding selects and a load-use freeze.
// Outputs are combinational (0-cycle); history/counter registered. Freeze holds decode until the load becomes forwardable.
module hazard_forward_unit #(
    parameter int NREG       = 8,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16,
    localparam int IDX_W     = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic             src1_valid,
    input  logic [IDX_W-1:0] src1_idx,
    input  logic             src2_valid,
    input  logic [IDX_W-1:0] src2_idx,
    input  logic             dst_valid,
    input  logic [IDX_W-1:0] dst_idx,
    input  logic             dst_is_load,
    input  logic             flush,
    output logic             freeze,
    output logic [2:0]       fwd_sel1,
    output logic [2:0]       fwd_sel2,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [FWD_DEPTH:1] v_q, v_d;
    logic [FWD_DEPTH:1] ld_q, ld_d;
    logic [IDX_W-1:0]   idx_q [1:FWD_DEPTH];
    logic [IDX_W-1:0]   idx_d [1:FWD_DEPTH];
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic [2:0] sel1, sel2;
    logic       nrdy1, nrdy2;

    // Oldest-to-youngest scan so the youngest matching entry overwrites.
    always_comb begin
        sel1  = '0;
        sel2  = '0;
        nrdy1 = 1'b0;
        nrdy2 = 1'b0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (issue_valid && src1_valid && v_q[k] && (idx_q[k] == src1_idx)) begin
                sel1  = 3'(k);
                nrdy1 = ld_q[k] && (k < LOAD_STAGE);
            end
            if (issue_valid && src2_valid && v_q[k] && (idx_q[k] == src2_idx)) begin
                sel2  = 3'(k);
                nrdy2 = ld_q[k] && (k < LOAD_STAGE);
            end
        end
    end

    always_comb begin
        freeze   = !flush && (nrdy1 || nrdy2);
        fwd_sel1 = flush ? 3'd0 : sel1;
        fwd_sel2 = flush ? 3'd0 : sel2;
    end

    // A frozen or squashed decode slot enters the pipe as a bubble.
    always_comb begin
        v_d[1]   = issue_valid && dst_valid && !freeze && !flush;
        ld_d[1]  = dst_is_load;
        idx_d[1] = dst_idx;
        for (int k = 2; k <= FWD_DEPTH; k++) begin
            v_d[k]   = v_q[k-1];
            ld_d[k]  = ld_q[k-1];
            idx_d[k] = idx_q[k-1];
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (freeze && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q         <= '0;
            ld_q        <= '0;
            stall_cnt_q <= '0;
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                idx_q[k] <= '0;
            end
        end else begin
            v_q         <= v_d;
            ld_q        <= ld_d;
            stall_cnt_q <= stall_cnt_d;
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                idx_q[k] <= idx_d[k];
            end
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench: default instance (depth 2, load stage 2) and a depth-3 / load-stage-3 / 2-bit-counter instance.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid, src1_valid, src2_valid, dst_valid, dst_is_load, flush;
    logic [2:0] src1_idx, src2_idx, dst_idx;

    logic        fz0, fz1;
    logic [2:0]  s1_0, s2_0, s1_1, s2_1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_forward_unit u0 (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
        .src1_valid(src1_valid), .src1_idx(src1_idx),
        .src2_valid(src2_valid), .src2_idx(src2_idx),
        .dst_valid(dst_valid), .dst_idx(dst_idx), .dst_is_load(dst_is_load),
        .flush(flush), .freeze(fz0), .fwd_sel1(s1_0), .fwd_sel2(s2_0), .stall_cnt(cnt0)
    );

    hazard_forward_unit #(.NREG(8), .FWD_DEPTH(3), .LOAD_STAGE(3), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
        .src1_valid(src1_valid), .src1_idx(src1_idx),
        .src2_valid(src2_valid), .src2_idx(src2_idx),
        .dst_valid(dst_valid), .dst_idx(dst_idx), .dst_is_load(dst_is_load),
        .flush(flush), .freeze(fz1), .fwd_sel1(s1_1), .fwd_sel2(s2_1), .stall_cnt(cnt1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic iv, input logic a_v, input logic [2:0] a,
                       input logic b_v, input logic [2:0] b,
                       input logic d_v, input logic [2:0] d, input logic ld, input logic fl);
        issue_valid = iv; src1_valid = a_v; src1_idx = a; src2_valid = b_v; src2_idx = b;
        dst_valid = d_v; dst_idx = d; dst_is_load = ld; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drv(1, 1, 3'd3, 1, 3'd3, 1, 3'd3, 1, 0);
        @(negedge clk);
        chk("rst_freeze", fz0, 0);
        chk("rst_sel1", s1_0, 0);
        chk("rst_sel2", s2_0, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        tick();
        rst_n = 1'b1;

        // ALU forwarding from stage 1, then stage 2; issue_valid=0 blocks matches
        drv(1, 0, 3'd0, 0, 3'd0, 1, 3'd3, 0, 0); @(negedge clk); chk("add_fz", fz0, 0); tick();
        drv(1, 1, 3'd3, 0, 3'd0, 0, 3'd0, 0, 0); @(negedge clk);
        chk("alu_k1_sel1", s1_0, 1); chk("alu_k1_sel2", s2_0, 0); chk("alu_k1_fz", fz0, 0); tick();
        drv(1, 1, 3'd3, 1, 3'd3, 0, 3'd0, 0, 0); @(negedge clk);
        chk("alu_k2_sel1", s1_0, 2); chk("same_reg_sel2", s2_0, 2); tick();
        drv(1, 0, 3'd0, 0, 3'd0, 1, 3'd7, 0, 0); tick();
        drv(0, 1, 3'd7, 0, 3'd0, 0, 3'd0, 0, 0); @(negedge clk);
        chk("noissue_sel1", s1_0, 0); chk("noissue_fz", fz0, 0); tick();

        // Load-use on src2 with LOAD_STAGE=2: one frozen cycle
        drv(1, 0, 3'd0, 0, 3'd0, 1, 3'd2, 1, 0); tick();
        drv(1, 0, 3'd0, 1, 3'd2, 0, 3'd0, 0, 0); @(negedge clk);
        chk("lu_fz", fz0, 1); chk("lu_sel2_k1", s2_0, 1); tick();
        @(negedge clk);
        chk("lu_release_fz", fz0, 0); chk("lu_sel2_k2", s2_0, 2); chk("lu_cnt", cnt0, 1); tick();

        // Youngest writer wins; a young load writer freezes
        drv(1, 0, 3'd0, 0, 3'd0, 1, 3'd1, 0, 0); tick(); tick();
        drv(1, 1, 3'd1, 0, 3'd0, 0, 3'd0, 0, 0); @(negedge clk);
        chk("young_sel1", s1_0, 1); chk("young_fz", fz0, 0); tick();
        drv(1, 0, 3'd0, 0, 3'd0, 1, 3'd1, 0, 0); tick();
        drv(1, 0, 3'd0, 0, 3'd0, 1, 3'd1, 1, 0); tick();
        drv(1, 1, 3'd1, 0, 3'd0, 0, 3'd0, 0, 0); @(negedge clk);
        chk("young_ld_sel1", s1_0, 1); chk("young_ld_fz", fz0, 1); tick();
        @(negedge clk);
        chk("young_ld_rel_sel1", s1_0, 2); chk("young_ld_rel_fz", fz0, 0); chk("young_ld_cnt", cnt0, 2); tick();

        // Flush overrides a load-use hazard and squashes the destination
        drv(1, 0, 3'd0, 0, 3'd0, 1, 3'd5, 1, 0); tick();
        drv(1, 1, 3'd5, 0, 3'd0, 1, 3'd6, 0, 1); @(negedge clk);
        chk("flush_fz", fz0, 0); chk("flush_sel1", s1_0, 0); chk("flush_sel2", s2_0, 0); tick();
        drv(1, 1, 3'd6, 1, 3'd5, 0, 3'd0, 0, 0); @(negedge clk);
        chk("flush_bubble_sel1", s1_0, 0); chk("flush_older_sel2", s2_0, 2);
        chk("flush_fz_after", fz0, 0); chk("flush_cnt", cnt0, 2); tick();

        rst_n = 1'b0; #1;
        chk("rst2_cnt0", cnt0, 0); chk("rst2_cnt1", cnt1, 0);
        tick(); rst_n = 1'b1;

        // Depth 3, LOAD_STAGE 3: two frozen cycles, forward from stage 3, then aged out
        drv(1, 0, 3'd0, 0, 3'd0, 1, 3'd4, 1, 0); tick();
        drv(1, 1, 3'd4, 0, 3'd0, 0, 3'd0, 0, 0); @(negedge clk);
        chk("d3_fz_c1", fz1, 1); chk("d3_sel_c1", s1_1, 1); tick();
        @(negedge clk);
        chk("d3_fz_c2", fz1, 1); chk("d3_sel_c2", s1_1, 2); chk("d3_cnt_c2", cnt1, 1); tick();
        @(negedge clk);
        chk("d3_rel_fz", fz1, 0); chk("d3_rel_sel", s1_1, 3); chk("d3_cnt", cnt1, 2); tick();
        @(negedge clk);
        chk("d3_aged_sel", s1_1, 0); chk("d3_aged_fz", fz1, 0); tick();

        // Reset during the second freeze cycle
        drv(1, 0, 3'd0, 0, 3'd0, 1, 3'd4, 1, 0); tick();
        drv(1, 1, 3'd4, 0, 3'd0, 0, 3'd0, 0, 0); tick();
        @(negedge clk);
        chk("mid_fz_before", fz1, 1); chk("mid_cnt_before", cnt1, 3);
        rst_n = 1'b0; #1;
        chk("mid_rst_fz", fz1, 0); chk("mid_rst_cnt", cnt1, 0); chk("mid_rst_sel", s1_1, 0);
        tick(); rst_n = 1'b1;
        @(negedge clk);
        chk("mid_hist_sel", s1_1, 0); chk("mid_hist_fz", fz1, 0); tick();

        // Counter saturation on the 2-bit instance
        for (int i = 0; i < 3; i++) begin
            drv(1, 0, 3'd0, 0, 3'd0, 1, 3'd4, 1, 0); tick();
            drv(1, 1, 3'd4, 0, 3'd0, 0, 3'd0, 0, 0);
            @(negedge clk); chk("sat_fz_a", fz1, 1); tick();
            @(negedge clk); chk("sat_fz_b", fz1, 1); tick();
            @(negedge clk); chk("sat_fz_c", fz1, 0);
            chk("sat_cnt", cnt1, (2 * (i + 1) > 3) ? 3 : 2 * (i + 1)); tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
